life_frame_scanout: RTL and testbench

//  Reader/consumer for the Game-of-Life generator's 256-bit board output (gout).
//  - Snapshots a board on request, then scans it row by row to a shift-register
//    LED matrix: serial data, shift strobe, latch pulse, row select, output enable.
//  - The generator can keep iterating while a frame is displayed; each frame is

---
 rtl/life_pkg.sv | 24 ++
 rtl/scan_row_piso.sv | 42 ++++
 rtl/life_frame_scanout.sv | 214 +++++++++++++++++++++
 tb/tb_life_frame_scanout.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared board geometry and scan state encoding for the
//                Game-of-Life frame scan-out block.
//                Contents: ROWS_DEF/COLS_DEF board defaults, BOARD_W,
//                scan_state_t {IDLE, SHIFT, LATCH, DWELL}.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 16;
    localparam int BOARD_W  = ROWS_DEF * COLS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DWELL = 2'd3
    } scan_state_t;

endpackage : life_pkg
`default_nettype wire

// File: rtl/scan_row_piso.sv
`default_nettype none
// ============================================================================
//  Module      : scan_row_piso
//  Description : COLS-bit parallel-in / serial-out shifter, MSB first.
//                load_i has priority over shift_i; zeros fill from the LSB.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-high clear
//                load_i   - load din_i into the shifter
//                shift_i  - shift one position towards the MSB
//                din_i    - parallel row data
//                msb_o    - current serial bit (shifter MSB)
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_row_piso
    import life_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [COLS-1:0] din_i,
    output logic            msb_o
);

    logic [COLS-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[COLS-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[COLS-1];

endmodule : scan_row_piso
`default_nettype wire

// File: rtl/life_frame_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : life_frame_scanout
//  Description : Snapshots a Game-of-Life board on request and scans it row
//                by row to a shift-register LED matrix. Each frame is scanned
//                from a private copy, so the generator may keep iterating.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                grid       - board, row r = grid[COLS*r +: COLS]
//                frame_req  - 1-cycle snapshot/scan request
//                enable     - scan permitted; low aborts a scan
//                sdo        - serial pixel data (MSB of row first)
//                sdo_vld    - shift strobe
//                lat        - 1-cycle latch pulse
//                oe_n       - active-low row output enable
//                row_idx    - row currently lit
//                busy       - scan in progress
//                frame_done - 1-cycle pulse after the last row's dwell
//                overrun    - sticky, a request was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module life_frame_scanout
    import life_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int DWELL_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ROWS*COLS-1:0]    grid,
    input  logic                    frame_req,
    input  logic                    enable,
    output logic                    sdo,
    output logic                    sdo_vld,
    output logic                    lat,
    output logic                    oe_n,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW_W  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_CYC - 1);

    scan_state_t            state_q, state_d;
    logic [ROWS*COLS-1:0]   frame_q, frame_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [DW_W-1:0]        dwell_q, dwell_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [ROW_W-1:0]       row_idx_q, row_idx_d;
    logic                   sdo_vld_q, lat_q, oe_n_q, busy_q, frame_done_q;
    logic                   frame_done_d;

    logic                   piso_load;
    logic                   piso_shift;
    logic [COLS-1:0]        piso_din;
    logic                   piso_msb;
    logic [ROW_W-1:0]       row_nxt;

    // Row view of the frame copy so the next row can be picked by index.
    logic [COLS-1:0]        frame_rows [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign frame_rows[r] = frame_q[COLS*r +: COLS];
    end

    assign row_nxt = row_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        row_d        = row_q;
        col_d        = col_q;
        dwell_d      = dwell_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        row_idx_d    = row_idx_q;
        frame_done_d = 1'b0;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_din     = grid[COLS-1:0];

        // A request during a scan (including its final dwell cycle) is
        // queued once; any further request before it is served is lost.
        if ((state_q != IDLE) && frame_req) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable && (frame_req || pending_q)) begin
                    // Row 0 is loaded straight from grid, since the frame
                    // copy only becomes visible after this edge.
                    frame_d   = grid;
                    pending_d = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    piso_load = 1'b1;
                    piso_din  = grid[COLS-1:0];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                piso_shift = 1'b1;
                if (col_q == COL_LAST) begin
                    row_idx_d = row_q;
                    state_d   = LATCH;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            LATCH: begin
                dwell_d = '0;
                state_d = DWELL;
            end
            DWELL: begin
                if (dwell_q == DW_LAST) begin
                    if (row_q == ROW_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        row_d     = row_nxt;
                        col_d     = '0;
                        piso_load = 1'b1;
                        piso_din  = frame_rows[row_nxt];
                        state_d   = SHIFT;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort: back to IDLE with the matrix blanked; a queued request
        // survives and restarts the scan once enable returns.
        if ((state_q != IDLE) && !enable) begin
            state_d      = IDLE;
            frame_done_d = 1'b0;
            piso_load    = 1'b0;
            piso_shift   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            row_idx_q    <= '0;
            sdo_vld_q    <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            row_idx_q    <= row_idx_d;
            // Outputs are registered decodes of the next state so they
            // change exactly on the state transitions.
            sdo_vld_q    <= (state_d == SHIFT);
            lat_q        <= (state_d == LATCH);
            oe_n_q       <= (state_d != DWELL);
            busy_q       <= (state_d != IDLE);
            frame_done_q <= frame_done_d;
        end
    end

    scan_row_piso #(
        .COLS    (COLS)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .din_i   (piso_din),
        .msb_o   (piso_msb)
    );

    // Keep the data line quiet outside shift windows (e.g. after an abort).
    assign sdo        = piso_msb & sdo_vld_q;
    assign sdo_vld    = sdo_vld_q;
    assign lat        = lat_q;
    assign oe_n       = oe_n_q;
    assign row_idx    = row_idx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule : life_frame_scanout
`default_nettype wire

// File: tb/tb_life_frame_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_frame_scanout
//  Description : Self-checking bench for life_frame_scanout (16x16 board,
//                DWELL_CYC=4, 336-cycle frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_frame_scanout;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] grid;
    logic         frame_req;
    logic         enable;
    logic         sdo, sdo_vld, lat, oe_n, busy, frame_done, overrun;
    logic [3:0]   row_idx;

    int checks   = 0;
    int failures = 0;

    logic [15:0]  cap_rows [16];
    int           cap_lat, cap_oe, cap_done, cap_idx_err;
    bit           cap_to;

    typedef struct {
        logic [255:0] grid;
        int           row;
        logic [15:0]  exp_bits;
    } vec_t;

    vec_t vecs [4];

    life_frame_scanout #(
        .ROWS       (16),
        .COLS       (16),
        .DWELL_CYC  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .grid       (grid),
        .frame_req  (frame_req),
        .enable     (enable),
        .sdo        (sdo),
        .sdo_vld    (sdo_vld),
        .lat        (lat),
        .oe_n       (oe_n),
        .row_idx    (row_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse a request from IDLE; the next cycle must already be shifting.
    task automatic start_req(input string tag);
        frame_req = 1'b1;
        tick;
        frame_req = 1'b0;
        chk({tag, ".first_vld"}, {31'd0, sdo_vld}, 32'd1);
    endtask

    // Called in the first shift cycle of a frame; runs until frame_done,
    // optionally pulsing frame_req / changing grid at given cycle offsets.
    task automatic capture(input int req_a, input int req_b, input int req_c,
                           input int chg_c, input logic [255:0] chg_grid);
        logic [15:0] cur;
        int          c;
        cur = '0;
        c   = 0;
        cap_lat = 0; cap_oe = 0; cap_idx_err = 0; cap_to = 1'b0;
        for (int r = 0; r < 16; r++) cap_rows[r] = '0;
        while (!frame_done) begin
            if (c >= 600) begin
                cap_to = 1'b1;
                break;
            end
            if (sdo_vld) cur = {cur[14:0], sdo};
            if (lat) begin
                if (cap_lat < 16) cap_rows[cap_lat] = cur;
                cap_lat++;
            end
            if (!oe_n) begin
                cap_oe++;
                if (int'(row_idx) != cap_lat - 1) cap_idx_err++;
            end
            frame_req = (c == req_a) || (c == req_b) || (c == req_c);
            if (c == chg_c) grid = chg_grid;
            tick;
            c++;
        end
        frame_req = 1'b0;
        cap_done  = c;
    endtask

    task automatic check_frame(input string tag, input logic [255:0] exp_grid);
        int bad;
        bad = 0;
        for (int r = 0; r < 16; r++)
            if (cap_rows[r] !== exp_grid[16*r +: 16]) bad++;
        chk({tag, ".timeout"}, {31'd0, cap_to}, 32'd0);
        chk({tag, ".rows_bad"}, bad, 32'd0);
        chk({tag, ".lat_cnt"}, cap_lat, 32'd16);
        chk({tag, ".done_cyc"}, cap_done, 32'd336);
        chk({tag, ".oe_cyc"}, cap_oe, 32'd64);
        chk({tag, ".row_idx_err"}, cap_idx_err, 32'd0);
    endtask

    localparam logic [255:0] GA = {16'hF00F, 208'h0, 32'hCAFE_0001};
    localparam logic [255:0] GB = {32'h1111_7777, 224'h0};
    localparam logic [255:0] GD = {192'h0, 64'h0123_4567_89AB_CDEF};

    initial begin
        logic [15:0] bits;
        int          n;
        int          err;

        vecs[0] = '{grid: {224'h0, 32'hFFFF_FFFF},          row: 1,  exp_bits: 16'hFFFF};
        vecs[1] = '{grid: {240'h0, 16'h8001},               row: 0,  exp_bits: 16'h8001};
        vecs[2] = '{grid: {16'hA5C3, 224'h0, 16'h1234},     row: 15, exp_bits: 16'hA5C3};
        vecs[3] = '{grid: {112'h0, 16'hBEEF, 128'h0},       row: 8,  exp_bits: 16'hBEEF};

        reset = 1'b1; grid = '0; frame_req = 1'b0; enable = 1'b1;
        repeat (2) tick;
        chk("rst.sdo",        {31'd0, sdo},        32'd0);
        chk("rst.sdo_vld",    {31'd0, sdo_vld},    32'd0);
        chk("rst.lat",        {31'd0, lat},        32'd0);
        chk("rst.oe_n",       {31'd0, oe_n},       32'd1);
        chk("rst.row_idx",    {28'd0, row_idx},    32'd0);
        chk("rst.busy",       {31'd0, busy},       32'd0);
        chk("rst.frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst.overrun",    {31'd0, overrun},    32'd0);
        reset = 1'b0;
        repeat (2) tick;
        chk("idle.busy", {31'd0, busy}, 32'd0);

        // Table: one full frame per vector.
        for (int i = 0; i < 4; i++) begin
            grid = vecs[i].grid;
            start_req($sformatf("vec%0d", i));
            capture(-1, -1, -1, -1, '0);
            check_frame($sformatf("vec%0d", i), vecs[i].grid);
            chk($sformatf("vec%0d.row_bits", i), {16'd0, cap_rows[vecs[i].row]}, {16'd0, vecs[i].exp_bits});
            tick;
            chk($sformatf("vec%0d.done_pulse", i), {30'd0, frame_done, busy}, 32'd0);
        end

        // Row 0 timing: 16 shift cycles, one latch, 4 lit dwell cycles.
        grid = {240'h0, 16'h8001};
        start_req("t2");
        bits = '0; n = 0;
        for (int k = 0; k < 16; k++) begin
            bits = {bits[14:0], sdo};
            if (sdo_vld) n++;
            tick;
        end
        chk("t2.bits", {16'd0, bits}, 32'h8001);
        chk("t2.vld_cnt", n, 32'd16);
        chk("t2.lat", {29'd0, lat, sdo_vld, oe_n}, 32'b101);
        tick;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (!oe_n && row_idx == 4'd0) n++;
            tick;
        end
        chk("t2.dwell_cnt", n, 32'd4);
        chk("t2.row1_start", {30'd0, oe_n, sdo_vld}, 32'b11);
        enable = 1'b0;
        tick;
        enable = 1'b1;
        repeat (3) tick;
        chk("t2.abort_idle", {31'd0, busy}, 32'd0);

        // Pending request, grid changed after request, then overrun.
        grid = GA;
        start_req("t3a");
        capture(100, -1, -1, 150, GB);
        check_frame("t3a", GA);
        chk("t3a.overrun", {31'd0, overrun}, 32'd0);
        tick;
        chk("t3.restart", {30'd0, sdo_vld, busy}, 32'b11);
        capture(50, 120, 200, -1, '0);
        check_frame("t3b", GB);
        chk("t3b.overrun", {31'd0, overrun}, 32'd1);
        tick;
        chk("t3.extra", {31'd0, sdo_vld}, 32'd1);
        capture(-1, -1, -1, -1, '0);
        check_frame("t3c", GB);
        tick;
        err = 0;
        repeat (20) begin
            if (busy || sdo_vld) err++;
            tick;
        end
        chk("t3.no_more_frames", err, 32'd0);

        // Abort during row 5 shift with a pending request queued.
        grid = GD;
        start_req("t4");
        err = 0;
        for (int c = 0; c < 110; c++) begin
            frame_req = (c == 50);
            if (frame_done) err++;
            tick;
        end
        frame_req = 1'b0;
        chk("t4.in_shift", {31'd0, sdo_vld}, 32'd1);
        enable = 1'b0;
        tick;
        chk("t4.abort", {28'd0, oe_n, sdo_vld, busy, lat}, 32'b1000);
        repeat (20) begin
            if (frame_done || busy) err++;
            tick;
        end
        chk("t4.no_done", err, 32'd0);
        enable = 1'b1;
        tick;
        chk("t4.restart", {31'd0, sdo_vld}, 32'd1);
        capture(-1, -1, -1, -1, '0);
        check_frame("t4", GD);
        tick;

        // Asynchronous reset in row 3 dwell (overrun is still set here).
        start_req("t5");
        repeat (80) tick;
        chk("t5.pre", {27'd0, oe_n, row_idx}, {27'd0, 1'b0, 4'd3});
        #2 reset = 1'b1;
        #1;
        chk("t5.async", {25'd0, oe_n, busy, overrun, row_idx}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
        tick;
        reset = 1'b0;
        err = 0;
        repeat (40) begin
            if (busy || sdo_vld || lat || frame_done) err++;
            tick;
        end
        chk("t5.quiet", err, 32'd0);

        // Request ignored while disabled in IDLE, and not queued.
        enable = 1'b0;
        frame_req = 1'b1;
        tick;
        frame_req = 1'b0;
        repeat (10) tick;
        chk("t6.outs", {24'd0, sdo, sdo_vld, lat, oe_n, busy, frame_done, overrun, |row_idx}, 32'b0001_0000);
        enable = 1'b1;
        repeat (5) tick;
        chk("t6.no_pending", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_life_frame_scanout
`default_nettype wire
